// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_ACTIVE    = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_PARITY    = 4;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + PW'(1);
        if (pop_ok)  rd_d = rd_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and TXDATA/STATUS registers.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned          WORD_LEN   = 32,
    parameter logic [WORD_LEN-1:0]  BASE_ADDR  = 32'hFF00_0000,
    parameter int unsigned          CLK_FREQ   = 27_000_000,
    parameter int unsigned          BAUD       = 115_200,
    parameter int unsigned          FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                wen,
    input  logic [WORD_LEN-1:0] wdata,
    output logic                hit,
    output logic [WORD_LEN-1:0] rdata,
    output logic                tx,
    output logic                busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        bit_nxt;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              bit_end;

    logic              sel_tx, sel_status;
    logic              wr_tx, wr_status;
    logic              fifo_push, fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [WORD_LEN-1:0] status;
    logic              unused_bits;

    assign hit        = (d_addr[WORD_LEN-1:3] == BASE_ADDR[WORD_LEN-1:3]);
    assign sel_tx     = hit && (d_addr[2] == TXDATA_OFS[2]);
    assign sel_status = hit && (d_addr[2] == STATUS_OFS[2]);
    assign wr_tx      = wen && sel_tx;
    assign wr_status  = wen && sel_status;
    assign fifo_push  = wr_tx && !fifo_full;
    assign unused_bits = ^{d_addr[1:0], wdata[WORD_LEN-1:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                                   = '0;
        status[STAT_FULL]                        = fifo_full;
        status[STAT_EMPTY]                       = fifo_empty;
        status[STAT_ACTIVE]                      = (state_q != IDLE);
        status[STAT_OVF]                         = ovf_q;
        status[STAT_COUNT_LSB +: STAT_COUNT_W]   = 8'(fifo_count);
`ifdef UART_TX_PARITY_EN
        status[STAT_PARITY]                      = 1'b1;
`endif
    end

    assign rdata = sel_status ? status : '0;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || !fifo_empty;

    // A drop on a full FIFO outranks a clear request.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && wdata[3]) ovf_d = 1'b0;
        if (wr_tx && fifo_full)    ovf_d = 1'b1;
    end

    assign bit_end = (cnt_q == CNT_W'(DIV - 1));
    assign bit_nxt = bit_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                    cnt_d    = '0;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shift_q[bit_nxt];
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset drops any partial frame and returns the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode vector table, line-decoding monitor with byte scoreboard,
// and directed sequences for latency, overflow, back-to-back gaps and mid-frame reset.
module tb_mmio_uart_tx;

    localparam int unsigned WL       = 32;
    localparam int unsigned CLK_FREQ = 8;
    localparam int unsigned BAUD     = 1;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
    localparam logic [31:0] PAR_IND    = 32'h0000_0010;
`else
    localparam int unsigned FRAME_BITS = 10;
    localparam logic [31:0] PAR_IND    = 32'h0000_0000;
`endif
    localparam logic [31:0] A_TX = 32'hFF00_0000;
    localparam logic [31:0] A_ST = 32'hFF00_0004;

    logic          clk;
    logic          rst_n;
    logic [WL-1:0] d_addr;
    logic          wen;
    logic [WL-1:0] wdata;
    logic          hit;
    logic [WL-1:0] rdata;
    logic          tx;
    logic          busy;

    mmio_uart_tx #(
        .WORD_LEN   (WL),
        .BASE_ADDR  (32'hFF00_0000),
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_addr (d_addr),
        .wen    (wen),
        .wdata  (wdata),
        .hit    (hit),
        .rdata  (rdata),
        .tx     (tx),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    int         gap_q[$];
    int         idle_run = 0;

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } dec_vec_t;

    dec_vec_t vec[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        d_addr = a;
        wdata  = d;
        wen    = 1'b1;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        wen    = 1'b0;
        wdata  = '0;
        d_addr = A_ST;
        #1;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    // Line monitor: decodes frames from tx and checks them against the scoreboard.
    initial begin : monitor
        logic [10:0] bits;
        int          glitch;
        bit          aborted;
        logic [7:0]  eb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idle_run = 0;
            end else if (tx === 1'b0) begin
                gap_q.push_back(idle_run);
                bits    = '0;
                glitch  = 0;
                aborted = 1'b0;
                for (int k = 1; k < int'(FRAME_BITS * DIV); k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % DIV == 0) bits[k / DIV] = tx;
                    else if (tx !== bits[k / DIV]) glitch++;
                end
                idle_run = 0;
                if (!aborted) begin
                    chk("frame_stable", 32'(glitch), 32'd0);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, want no frame", bits[8:1]);
                    end else begin
                        eb = sb.pop_front();
                        chk("frame_data", 32'(bits[8:1]), 32'(eb));
`ifdef UART_TX_PARITY_EN
                        chk("frame_parity", 32'(bits[9]), 32'(^eb));
`endif
                        chk("frame_stop", 32'(bits[FRAME_BITS-1]), 32'd1);
                    end
                end
            end else begin
                idle_run++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int n_hi;

        vec[0] = '{32'hFF00_0004, 1'b1, 32'h0000_0002 | PAR_IND};
        vec[1] = '{32'hFF00_0000, 1'b1, 32'h0000_0000};
        vec[2] = '{32'hFF00_0005, 1'b1, 32'h0000_0002 | PAR_IND};
        vec[3] = '{32'hFF00_0007, 1'b1, 32'h0000_0002 | PAR_IND};
        vec[4] = '{32'hFF00_0003, 1'b1, 32'h0000_0000};
        vec[5] = '{32'hFF00_0008, 1'b0, 32'h0000_0000};
        vec[6] = '{32'h0000_1000, 1'b0, 32'h0000_0000};
        vec[7] = '{32'h7F00_0004, 1'b0, 32'h0000_0000};
        vec[8] = '{32'hFF00_000C, 1'b0, 32'h0000_0000};

        rst_n  = 1'b0;
        wen    = 1'b0;
        d_addr = '0;
        wdata  = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            d_addr = vec[i].addr;
            #1;
            chk("decode_hit", 32'(hit), 32'(vec[i].exp_hit));
            chk("decode_rdata", rdata, vec[i].exp_rdata);
        end

        // Single byte: pop latency and frame length.
        wr(A_TX, 32'h0000_0155);
        sb.push_back(8'h55);
        bus_idle();
        chk("pre_pop_tx", 32'(tx), 32'd1);
        chk("pre_pop_busy", 32'(busy), 32'd1);
        chk("pre_pop_status", rdata, 32'h0000_0100 | PAR_IND);
        @(negedge clk);
        #1;
        chk("start_tx", 32'(tx), 32'd0);
        chk("start_status", rdata, 32'h0000_0006 | PAR_IND);
        wait_idle(200, n);
        chk("frame_len", 32'(n), 32'(FRAME_BITS * DIV));

        // Burst of six into a 4-deep FIFO: one pops early, the sixth is dropped.
        repeat (3) @(negedge clk);
        gap_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr(A_TX, 32'h41 + 32'(i));
            if (i < 5) sb.push_back(8'(8'h41 + i));
        end
        bus_idle();
        chk("burst_status", rdata, 32'h0000_040D | PAR_IND);
        wr(A_TX, 32'h0000_0008);
        bus_idle();
        chk("ovf_kept_on_drop", rdata, 32'h0000_040D | PAR_IND);
        wr(A_ST, 32'h0000_0008);
        bus_idle();
        chk("ovf_cleared", rdata, 32'h0000_0405 | PAR_IND);
        wait_idle(1000, n);
        chk("burst_drain_busy", 32'(busy), 32'd0);
        chk("burst_end_status", rdata, 32'h0000_0002 | PAR_IND);
        chk("burst_sb_empty", 32'(sb.size()), 32'd0);
        chk("burst_frames", 32'(gap_q.size()), 32'd5);
        for (int i = 1; i < 5; i++) begin
            if (i < gap_q.size()) chk("b2b_gap", 32'(gap_q[i]), 32'd1);
        end

        // Parity-relevant bytes (also plain frames in the default build).
        wr(A_TX, 32'h0000_0007);
        sb.push_back(8'h07);
        wr(A_TX, 32'h0000_0003);
        sb.push_back(8'h03);
        bus_idle();
        wait_idle(400, n);
        chk("parity_drain_busy", 32'(busy), 32'd0);
        chk("parity_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a frame.
        wr(A_TX, 32'h0000_00A5);
        sb.push_back(8'hA5);
        bus_idle();
        n = 0;
        while (tx && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_frame_started", 32'(tx), 32'd0);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_async_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_status", rdata, 32'h0000_0002 | PAR_IND);
        n_hi = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (tx === 1'b1) n_hi++;
        end
        chk("rst_no_residue", 32'(n_hi), 32'd100);
        chk("rst_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
